// File: rtl/fpmin_stream_pkg.sv
// Shared types and ordering helpers for the streaming float argmin engine.
// FPMIN_STREAM_NAN_EN: when defined, NaNs map to the largest key so any number beats them.
package fpmin_pkg;

    localparam int FP_DW  = 32;
    localparam int FP_EW  = 8;
    localparam int LANE_W = 8;

    localparam logic [FP_DW-1:0] KEY_MAX  = '1;
    localparam logic [FP_DW-1:0] SIGN_BIT = {1'b1, {(FP_DW-1){1'b0}}};

    typedef struct packed {
        logic [FP_DW-1:0]  key;
        logic [FP_DW-1:0]  data;
        logic [LANE_W-1:0] lane;
    } node_t;

    function automatic logic fp_is_nan(input logic [FP_DW-1:0] x);
        return (&x[FP_DW-2 -: FP_EW]) && (|x[FP_DW-2-FP_EW:0]);
    endfunction

    // Sign-magnitude to unsigned-orderable mapping; -0 sorts just below +0.
    function automatic logic [FP_DW-1:0] fp_key(input logic [FP_DW-1:0] x);
        logic [FP_DW-1:0] k;
        k = x[FP_DW-1] ? ~x : (x | SIGN_BIT);
`ifdef FPMIN_STREAM_NAN_EN
        if (fp_is_nan(x)) k = KEY_MAX;
`endif
        return k;
    endfunction

endpackage

// File: rtl/fpmin_stream_if.sv
// Beat input and result output handshake bundle for fpmin_stream.
interface fpmin_stream_if #(
    parameter int DW = 32,
    parameter int TW = 8,
    parameter int IW = 3,
    parameter int CW = 16
);
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [TW*DW-1:0]  xd;
    logic              out_valid;
    logic              out_ready;
    logic [CW+IW-1:0]  out_idx;
    logic [DW-1:0]     out_data;
    logic              out_ovf;

    modport master (
        output in_valid, in_last, xd, out_ready,
        input  in_ready, out_valid, out_idx, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_last, xd, out_ready,
        output in_ready, out_valid, out_idx, out_data, out_ovf
    );
endinterface

// File: rtl/fpmin_stream_tree.sv
// Registered TW-input compare-select tree (IW levels) with beat/last/ovf sideband
// carried alongside; the whole pipe advances only when en is high.
module fpargmin_tree
    import fpmin_pkg::*;
#(
    parameter int TW = 8,
    parameter int IW = 3,
    parameter int CW = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                i_valid,
    input  logic                i_last,
    input  logic                i_ovf,
    input  logic [CW-1:0]       i_beat,
    input  logic [TW*FP_DW-1:0] i_x,
    output logic                o_valid,
    output logic                o_last,
    output logic                o_ovf,
    output logic [CW-1:0]       o_beat,
    output node_t               o_node
);
    localparam int NP = TW / 2;

    node_t         leaf   [TW];
    node_t         lvl_d  [IW][NP];
    node_t         lvl_q  [IW][NP];
    logic [IW-1:0] vld_d, vld_q, last_d, last_q, ovf_d, ovf_q;
    logic [CW-1:0] beat_d [IW];
    logic [CW-1:0] beat_q [IW];

    always_comb begin
        for (int k = 0; k < TW; k++) begin
            leaf[k].key  = fp_key(i_x[k*FP_DW +: FP_DW]);
            leaf[k].data = i_x[k*FP_DW +: FP_DW];
            leaf[k].lane = LANE_W'(k);
        end
    end

    // Pair (2j, 2j+1); on equal keys the lower-index side is kept.
    always_comb begin
        node_t a, b;
        a = '0;
        b = '0;
        for (int l = 0; l < IW; l++) begin
            if (l == 0) begin
                vld_d[l]  = i_valid;
                last_d[l] = i_last;
                ovf_d[l]  = i_ovf;
                beat_d[l] = i_beat;
            end else begin
                vld_d[l]  = vld_q[l-1];
                last_d[l] = last_q[l-1];
                ovf_d[l]  = ovf_q[l-1];
                beat_d[l] = beat_q[l-1];
            end
            for (int j = 0; j < NP; j++) begin
                if (l == 0) begin
                    a = leaf[2*j];
                    b = leaf[2*j+1];
                end else if (2*j+1 < NP) begin
                    a = lvl_q[l-1][2*j];
                    b = lvl_q[l-1][2*j+1];
                end else begin
                    a = '0;
                    b = '0;
                end
                lvl_d[l][j] = (b.key < a.key) ? b : a;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q  <= '0;
            last_q <= '0;
            ovf_q  <= '0;
            for (int l = 0; l < IW; l++) begin
                beat_q[l] <= '0;
                for (int j = 0; j < NP; j++) lvl_q[l][j] <= '0;
            end
        end else if (en) begin
            vld_q  <= vld_d;
            last_q <= last_d;
            ovf_q  <= ovf_d;
            beat_q <= beat_d;
            lvl_q  <= lvl_d;
        end
    end

    assign o_valid = vld_q[IW-1];
    assign o_last  = last_q[IW-1];
    assign o_ovf   = ovf_q[IW-1];
    assign o_beat  = beat_q[IW-1];
    assign o_node  = lvl_q[IW-1][0];
endmodule

// File: rtl/fpmin_stream.sv
// Streaming float argmin: beat handshake, beat counter, cross-beat accumulator, result regs.
// FPMIN_STREAM_NAN_EN (see fpmin_pkg) selects NaN-loses ordering; default is raw key order.
module fpmin_stream
    import fpmin_pkg::*;
#(
    parameter int TW = 8,
    parameter int IW = 3,
    parameter int CW = 16
) (
    input  logic           clk,
    input  logic           rst,
    fpmin_stream_if.slave  bus
);
    localparam logic [CW-1:0] BEAT_MAX = '1;

    logic              stall, en, accept;
    logic              rdy_q, rdy_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              cnt_ovf_q, cnt_ovf_d;
    logic              t_valid, t_last, t_ovf;
    logic [CW-1:0]     t_beat;
    node_t             t_node;
    logic              acc_vld_q, acc_vld_d;
    node_t             acc_node_q, acc_node_d;
    logic [CW-1:0]     acc_beat_q, acc_beat_d;
    logic              out_vld_q, out_vld_d;
    logic [CW+IW-1:0]  out_idx_q, out_idx_d;
    logic [FP_DW-1:0]  out_data_q, out_data_d;
    logic              out_ovf_q, out_ovf_d;
    logic              take;
    node_t             best_node;
    logic [CW-1:0]     best_beat;

    assign stall        = out_vld_q && !bus.out_ready;
    assign en           = !stall;
    assign bus.in_ready = rdy_q && en;
    assign accept       = bus.in_valid && rdy_q && en;

    fpargmin_tree #(.TW(TW), .IW(IW), .CW(CW)) u_tree (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .i_valid (accept),
        .i_last  (bus.in_last),
        .i_ovf   (cnt_ovf_q),
        .i_beat  (cnt_q),
        .i_x     (bus.xd),
        .o_valid (t_valid),
        .o_last  (t_last),
        .o_ovf   (t_ovf),
        .o_beat  (t_beat),
        .o_node  (t_node)
    );

    // cnt_ovf_q marks that the top beat index was already used in this frame.
    always_comb begin
        rdy_d     = 1'b1;
        cnt_d     = cnt_q;
        cnt_ovf_d = cnt_ovf_q;
        if (accept) begin
            if (bus.in_last) begin
                cnt_d     = '0;
                cnt_ovf_d = 1'b0;
            end else begin
                cnt_d     = (cnt_q == BEAT_MAX) ? cnt_q : cnt_q + 1'b1;
                cnt_ovf_d = cnt_ovf_q | (cnt_q == BEAT_MAX);
            end
        end
    end

    always_comb begin
        take       = !acc_vld_q || (t_node.key < acc_node_q.key);
        best_node  = take ? t_node : acc_node_q;
        best_beat  = take ? t_beat : acc_beat_q;
        acc_vld_d  = acc_vld_q;
        acc_node_d = acc_node_q;
        acc_beat_d = acc_beat_q;
        out_vld_d  = out_vld_q;
        out_idx_d  = out_idx_q;
        out_data_d = out_data_q;
        out_ovf_d  = out_ovf_q;
        if (en) begin
            if (bus.out_ready) out_vld_d = 1'b0;
            if (t_valid) begin
                if (t_last) begin
                    out_vld_d  = 1'b1;
                    out_idx_d  = {best_beat, best_node.lane[IW-1:0]};
                    out_data_d = best_node.data;
                    out_ovf_d  = t_ovf;
                    acc_vld_d  = 1'b0;
                end else begin
                    acc_vld_d  = 1'b1;
                    acc_node_d = best_node;
                    acc_beat_d = best_beat;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_q      <= 1'b0;
            cnt_q      <= '0;
            cnt_ovf_q  <= 1'b0;
            acc_vld_q  <= 1'b0;
            acc_node_q <= '0;
            acc_beat_q <= '0;
            out_vld_q  <= 1'b0;
            out_idx_q  <= '0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
        end else begin
            rdy_q      <= rdy_d;
            cnt_q      <= cnt_d;
            cnt_ovf_q  <= cnt_ovf_d;
            acc_vld_q  <= acc_vld_d;
            acc_node_q <= acc_node_d;
            acc_beat_q <= acc_beat_d;
            out_vld_q  <= out_vld_d;
            out_idx_q  <= out_idx_d;
            out_data_q <= out_data_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

    assign bus.out_valid = out_vld_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_fpmin_stream.sv
// Scoreboard bench for fpmin_stream (TW=8, CW=2 so the overflow boundary is reachable).
module tb_fpmin_stream;
    localparam int TW = 8;
    localparam int IW = 3;
    localparam int CW = 2;
    localparam int DW = 32;
    localparam int NBMAX = 1 << CW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fpmin_stream_if #(.DW(DW), .TW(TW), .IW(IW), .CW(CW)) bus ();
    fpmin_stream #(.TW(TW), .IW(IW), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [CW+IW-1:0] idx;
        logic [DW-1:0]    data;
        logic             ovf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec  = 0;
    int   n_miss = 0;
    int   cyc    = 0;

    bit          m_have = 0;
    logic [31:0] m_key, m_data;
    int          m_beat, m_lane, m_nb = 0;
    logic [31:0] ln [TW];
    logic [31:0] hold_d;
    logic [CW+IW-1:0] hold_i;
    int          lat, t0, sw;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fkey(input logic [31:0] x);
`ifdef FPMIN_STREAM_NAN_EN
        if (x[30:23] == 8'hFF && x[22:0] != 23'd0) return 32'hFFFF_FFFF;
`endif
        return x[31] ? ~x : (x | 32'h8000_0000);
    endfunction

    task automatic model_beat(input logic [TW*DW-1:0] x, input bit last);
        logic [31:0] v, kv;
        exp_t e;
        for (int k = 0; k < TW; k++) begin
            v  = x[k*DW +: DW];
            kv = fkey(v);
            if (!m_have || kv < m_key) begin
                m_have = 1; m_key = kv; m_data = v; m_beat = m_nb; m_lane = k;
            end
        end
        m_nb++;
        if (last) begin
            e.idx  = (CW+IW)'(((m_beat > NBMAX-1) ? NBMAX-1 : m_beat) * TW + m_lane);
            e.data = m_data;
            e.ovf  = (m_nb > NBMAX);
            sb.push_back(e);
            m_have = 0;
            m_nb   = 0;
        end
    endtask

    function automatic logic [TW*DW-1:0] pack_lanes();
        logic [TW*DW-1:0] x;
        for (int k = 0; k < TW; k++) x[k*DW +: DW] = ln[k];
        return x;
    endfunction

    task automatic set_all(input logic [31:0] v);
        for (int k = 0; k < TW; k++) ln[k] = v;
    endtask

    task automatic drive_beat(input bit last);
        logic [TW*DW-1:0] x;
        bit ok;
        int n;
        x = pack_lanes(); ok = 0; n = 0;
        bus.in_valid = 1'b1; bus.xd = x; bus.in_last = last;
        while (!ok && n < 200) begin
            @(negedge clk); ok = bus.in_ready;
            @(posedge clk); n++;
        end
        #1;
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        if (ok) model_beat(x, last);
        else check_val("accept_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin @(posedge clk); n++; end
        #1;
        check_val("drain", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) check_val("spurious_out", 1, 0);
            else begin
                mon_e = sb.pop_front();
                check_val("out_idx", bus.out_idx, mon_e.idx);
                check_val("out_data", bus.out_data, mon_e.data);
                check_val("out_ovf", bus.out_ovf, mon_e.ovf);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] pool [8];
        int nb;
        pool = '{32'h3F800000, 32'hBF800000, 32'h00000000, 32'h80000000,
                 32'h40000000, 32'h7F800000, 32'hFF800000, 32'h3F000000};
        bus.in_valid = 0; bus.in_last = 0; bus.xd = '0; bus.out_ready = 1;
        #23;
        check_val("rst_in_ready", bus.in_ready, 0);
        check_val("rst_out_valid", bus.out_valid, 0);
        check_val("rst_out_idx", bus.out_idx, 0);
        check_val("rst_out_data", bus.out_data, 0);
        check_val("rst_out_ovf", bus.out_ovf, 0);
        rst = 1;
        @(negedge clk);
        check_val("in_ready_after_rst", bus.in_ready, 1);
        @(posedge clk); #1;

        // single beat, min -1.0 at lane 2, latency check
        ln = '{32'h40A00000, 32'h40400000, 32'hBF800000, 32'h40E00000,
               32'hBF800000, 32'h40000000, 32'h00000000, 32'h41100000};
        drive_beat(1);
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            if (bus.out_valid) break;
            @(posedge clk); lat++;
        end
        check_val("latency", lat, IW);
        wait_drain();

        // 3-beat frame, min in beat 2 lane 6; stray in_last without valid in between
        set_all(32'h40800000); drive_beat(0);
        bus.in_last = 1; @(posedge clk); #1; bus.in_last = 0;
        set_all(32'h40000000); drive_beat(0);
        set_all(32'h3F800000); ln[6] = 32'h3F000000; drive_beat(1);
        // tie across beats: earlier beat wins
        set_all(32'h40800000); ln[1] = 32'h3F000000; drive_beat(0);
        set_all(32'h40000000); drive_beat(0);
        set_all(32'h3F800000); ln[6] = 32'h3F000000; drive_beat(1);
        // +0 / -0
        set_all(32'h00000000); ln[3] = 32'h80000000; ln[5] = 32'h80000000; drive_beat(1);
        // NaN versus 1.0
        set_all(32'h7F800000); ln[0] = 32'h3F800000; ln[4] = 32'hFFC00000; drive_beat(1);
        wait_drain();

        // back-to-back single-beat frames
        t0 = cyc;
        for (int f = 0; f < 6; f++) begin
            set_all(32'h40000000); ln[f] = 32'hC0000000 + 32'(f); drive_beat(1);
        end
        check_val("throughput_cycles", cyc - t0, 6);
        wait_drain();

        // random multi-beat frames over a small value pool (ties likely)
        for (int r = 0; r < 8; r++) begin
            nb = $urandom_range(1, NBMAX);
            for (int b = 0; b < nb; b++) begin
                for (int k = 0; k < TW; k++) ln[k] = pool[$urandom_range(0, 7)];
                drive_beat(b == nb - 1);
            end
        end
        wait_drain();

        // output backpressure while frames stream
        fork
            begin
                for (int f = 0; f < 6; f++) begin
                    set_all(32'h41000000); ln[7 - f] = 32'h3E800000 + 32'(f); drive_beat(1);
                end
            end
            begin
                @(posedge clk); #1; bus.out_ready = 0;
                sw = 0;
                while (sw < 50) begin
                    @(negedge clk);
                    if (bus.out_valid) break;
                    sw++;
                end
                check_val("stall_valid_seen", bus.out_valid, 1);
                hold_d = bus.out_data; hold_i = bus.out_idx;
                repeat (5) begin
                    @(negedge clk);
                    check_val("stall_in_ready", bus.in_ready, 0);
                    check_val("stall_hold_data", bus.out_data, hold_d);
                    check_val("stall_hold_idx", bus.out_idx, hold_i);
                end
                @(posedge clk); #1; bus.out_ready = 1;
            end
        join
        wait_drain();

        // beat-count boundary: 4 beats fit, 5 overflow, then sticky clears
        for (int b = 0; b < 4; b++) begin
            set_all(32'h3F800000); if (b == 3) ln[7] = 32'h3F000000; drive_beat(b == 3);
        end
        for (int b = 0; b < 5; b++) begin
            set_all(32'h3F800000); if (b == 4) ln[2] = 32'h3F000000; drive_beat(b == 4);
        end
        for (int b = 0; b < 2; b++) begin
            set_all(32'h3F800000); if (b == 1) ln[0] = 32'h3F000000; drive_beat(b == 1);
        end
        wait_drain();

        // reset with a completed frame still inside the tree
        set_all(32'h40000000); drive_beat(0);
        set_all(32'hC0000000); drive_beat(1);
        rst = 0;
        sb.delete(); m_have = 0; m_nb = 0;
        #2;
        check_val("midrst_out_valid", bus.out_valid, 0);
        check_val("midrst_in_ready", bus.in_ready, 0);
        @(negedge clk); rst = 1;
        @(posedge clk); #1;
        repeat (6) begin
            @(negedge clk);
            check_val("post_rst_no_out", bus.out_valid, 0);
        end
        @(posedge clk); #1;
        set_all(32'h40400000); ln[4] = 32'h3F800000; drive_beat(0);
        set_all(32'h40400000); ln[1] = 32'h3F800000; drive_beat(1);
        wait_drain();

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
